// File: rtl/gate_pkg.sv
// Shared definitions for the gate unit family: opcode encodings and the
// packed result-record width helper.
package gate_pkg;

  localparam logic [2:0] OP_AND     = 3'b000;
  localparam logic [2:0] OP_OR      = 3'b001;
  localparam logic [2:0] OP_XOR     = 3'b010;
  localparam logic [2:0] OP_NAND    = 3'b011;
  localparam logic [2:0] OP_NOR     = 3'b100;
  localparam logic [2:0] OP_XNOR    = 3'b101;
  localparam logic [2:0] OP_NOTA    = 3'b110;
  localparam logic [2:0] OP_ILLEGAL = 3'b111;

  // Width of one packed result record {y, y_pop, y_par, op_err}.
  function automatic int res_w(input int width);
    return width + $clog2(width + 1) + 2;
  endfunction

endpackage

// File: rtl/gate_unit_core.sv
// Combinational gate datapath: bitwise op on a/b, plus popcount and parity
// of the result. Illegal opcodes yield an all-zero result with op_err set.
module gate_unit_core
  import gate_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] y,
  output logic [CNT_W-1:0] y_pop,
  output logic             y_par,
  output logic             op_err
);

  // Select the bitwise operation; illegal op forces a zero result.
  always_comb begin
    y      = '0;
    op_err = 1'b0;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NAND: y = ~(a & b);
      OP_NOR:  y = ~(a | b);
      OP_XNOR: y = ~(a ^ b);
      OP_NOTA: y = ~a;
      default: begin
        y      = '0;
        op_err = 1'b1;
      end
    endcase
  end

  // Population count and parity of the selected result.
  always_comb begin
    y_pop = '0;
    for (int i = 0; i < WIDTH; i++) begin
      y_pop = y_pop + CNT_W'(y[i]);
    end
    y_par = ^y;
  end

endmodule

// File: rtl/gate_unit_pipe.sv
// Registered gate unit with a two-entry (MAIN + SKID) output buffer.
//
// Handshake: a beat transfers on the input side when in_valid && in_ready
// at a rising edge, and on the output side when out_valid && out_ready.
// A producer may not retract or alter a valid beat until it transfers.
// in_ready is a registered flag (= SKID empty), so it never depends
// combinationally on out_ready; the SKID entry absorbs the one beat that
// may arrive in the cycle the consumer stalls.
module gate_unit_pipe
  import gate_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic [CNT_W-1:0] y_pop,
  output logic             y_par,
  output logic             op_err
);

  localparam int RW = WIDTH + CNT_W + 2;

  logic [WIDTH-1:0] core_y;
  logic [CNT_W-1:0] core_pop;
  logic             core_par;
  logic             core_err;
  logic [RW-1:0]    core_res;

  logic [RW-1:0]    main_q, main_n;
  logic [RW-1:0]    skid_q, skid_n;
  logic             main_vld, main_vld_n;
  logic             skid_vld, skid_vld_n;
  logic             in_ready_q;
  logic             accept;
  logic             emit;

  gate_unit_core #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_core (
    .a      (a),
    .b      (b),
    .op     (op),
    .y      (core_y),
    .y_pop  (core_pop),
    .y_par  (core_par),
    .op_err (core_err)
  );

  assign core_res = {core_y, core_pop, core_par, core_err};
  assign accept   = in_valid && in_ready_q;
  assign emit     = main_vld && out_ready;

  // Next-state of the two buffer entries; SKID always drains into MAIN first.
  always_comb begin
    main_n     = main_q;
    main_vld_n = main_vld;
    skid_n     = skid_q;
    skid_vld_n = skid_vld;
    if (!main_vld || emit) begin
      if (skid_vld) begin
        main_n     = skid_q;
        main_vld_n = 1'b1;
        skid_vld_n = 1'b0;
      end else if (accept) begin
        main_n     = core_res;
        main_vld_n = 1'b1;
      end else begin
        main_vld_n = 1'b0;
      end
    end else if (accept) begin
      skid_n     = core_res;
      skid_vld_n = 1'b1;
    end
  end

  // Buffer registers; reset discards every held beat immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_vld   <= 1'b0;
      skid_vld   <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      main_q     <= main_n;
      skid_q     <= skid_n;
      main_vld   <= main_vld_n;
      skid_vld   <= skid_vld_n;
      in_ready_q <= !skid_vld_n;
    end
  end

  assign in_ready                     = in_ready_q;
  assign out_valid                    = main_vld;
  assign {y, y_pop, y_par, op_err}    = main_q;

endmodule
